// File: rtl/audio_pkg.sv
// Shared constants, state encoding and gain helper for the stereo mixer.
package audio_pkg;

    // Stereo arrangement select values (3 decodes as mono too)
    localparam logic [1:0] MODE_MONO = 2'd0;
    localparam logic [1:0] MODE_ABC  = 2'd1;
    localparam logic [1:0] MODE_ACB  = 2'd2;

    // Beeper contributions added to both sides
    localparam logic [14:0] EAR_LEVEL = 15'd4095;
    localparam logic [14:0] MIC_LEVEL = 15'd1024;

    // Unity gain; samples are scaled by gain/16
    localparam logic [4:0] GAIN_MAX = 5'd16;

    typedef enum logic [1:0] {
        StMuted    = 2'd0,
        StRampUp   = 2'd1,
        StActive   = 2'd2,
        StRampDown = 2'd3
    } gain_state_e;

    // Zero-extend a 12-bit channel level to the 15-bit mix width
    function automatic logic [14:0] ext12(input logic [11:0] v);
        return {3'b000, v};
    endfunction

    // (sample * gain) >> 4; gain never exceeds 16 so the result fits 15 bits
    function automatic logic [14:0] apply_gain(input logic [14:0] sample,
                                               input logic [4:0]  gain);
        logic [19:0] prod;
        prod = {5'd0, sample} * {15'd0, gain};
        return 15'(prod >> 4);
    endfunction

endpackage

// File: rtl/audio_mixer_if.sv
// Channel inputs, control and audio outputs of the mixer, bundled as one bus.
interface audio_mixer_if;

    logic        ce;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
    logic        ear;
    logic        mic;
    logic [1:0]  mode;
    logic        mute;
    logic [14:0] left;
    logic [14:0] right;
    logic        dsl;
    logic        dsr;

    // Source of levels/control, consumer of audio
    modport master (
        output ce, a, b, c, ear, mic, mode, mute,
        input  left, right, dsl, dsr
    );

    // The mixer itself
    modport slave (
        input  ce, a, b, c, ear, mic, mode, mute,
        output left, right, dsl, dsr
    );

endinterface

// File: rtl/sigma_delta.sv
// First-order sigma-delta modulator: carry out of a 15-bit accumulator is the
// 1-bit stream, so its density is sample / 32768.
module sigma_delta (
    input  logic        clock,
    input  logic        reset,     // asynchronous, active-low
    input  logic [14:0] sample_i,
    output logic        ds_o
);

    logic [14:0] acc_q, acc_d;
    logic        ds_q, ds_d;

    // Accumulate the sample; the overflow bit becomes the next output bit
    always_comb begin
        {ds_d, acc_d} = {1'b0, acc_q} + {1'b0, sample_i};
    end

    // Accumulator and output bit registers, updated every clock
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            ds_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ds_q  <= ds_d;
        end
    end

    assign ds_o = ds_q;

endmodule

// File: rtl/audio_mixer.sv
// PSG + beeper stereo mixer: registered mix, registered soft-mute gain stage
// with a prescaled ramp, and a sigma-delta bitstream per side.
module audio_mixer
    import audio_pkg::*;
#(
    parameter int unsigned RAMP_SHIFT = 8
) (
    input  logic          clock,
    input  logic          reset,     // asynchronous, active-low
    audio_mixer_if.slave  bus
);

    localparam logic [RAMP_SHIFT-1:0] PRESC_LAST = '1;
    localparam logic [RAMP_SHIFT-1:0] PRESC_ONE  = RAMP_SHIFT'(1);

    logic [14:0] a15, b15, c15;
    logic [14:0] base_l, base_r, extra;

    logic [14:0] mix_l_q, mix_l_d;
    logic [14:0] mix_r_q, mix_r_d;
    logic [14:0] left_q, left_d;
    logic [14:0] right_q, right_d;

    gain_state_e           state_q, state_d;
    logic [4:0]            gain_q, gain_d;
    logic [RAMP_SHIFT-1:0] presc_q, presc_d;
    logic                  wrap;

    logic dsl, dsr;

    assign a15 = ext12(bus.a);
    assign b15 = ext12(bus.b);
    assign c15 = ext12(bus.c);

    // Stage 1: arrange channels per mode, add beeper bits, capture on ce
    always_comb begin
        base_l = a15 + b15 + c15;
        base_r = a15 + b15 + c15;
        case (bus.mode)
            MODE_ABC: begin
                base_l = (a15 << 1) + b15;
                base_r = (c15 << 1) + b15;
            end
            MODE_ACB: begin
                base_l = (a15 << 1) + c15;
                base_r = (b15 << 1) + c15;
            end
            default: ;
        endcase
        extra = (bus.ear ? EAR_LEVEL : 15'd0) + (bus.mic ? MIC_LEVEL : 15'd0);

        mix_l_d = mix_l_q;
        mix_r_d = mix_r_q;
        if (bus.ce) begin
            mix_l_d = base_l + extra;
            mix_r_d = base_r + extra;
        end
    end

    // Stage 2: scale the held mix by the gain held before this edge
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        if (bus.ce) begin
            left_d  = apply_gain(mix_l_q, gain_q);
            right_d = apply_gain(mix_r_q, gain_q);
        end
    end

    // Gain ramp FSM: the prescaler only runs while ramping, and a direction
    // reversal takes effect without stepping the gain on that ce
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        presc_d = presc_q;
        wrap    = (presc_q == PRESC_LAST);

        if (bus.ce) begin
            unique case (state_q)
                StMuted: begin
                    presc_d = '0;
                    if (!bus.mute) begin
                        state_d = StRampUp;
                    end
                end
                StRampUp: begin
                    presc_d = presc_q + PRESC_ONE;
                    if (bus.mute) begin
                        state_d = StRampDown;
                    end else if (gain_q >= GAIN_MAX) begin
                        // Reached here via a brief mute blip at full gain
                        state_d = StActive;
                        presc_d = '0;
                    end else if (wrap) begin
                        gain_d = gain_q + 5'd1;
                        if (gain_q == GAIN_MAX - 5'd1) begin
                            state_d = StActive;
                            presc_d = '0;
                        end
                    end
                end
                StActive: begin
                    presc_d = '0;
                    if (bus.mute) begin
                        state_d = StRampDown;
                    end
                end
                StRampDown: begin
                    presc_d = presc_q + PRESC_ONE;
                    if (!bus.mute) begin
                        state_d = StRampUp;
                    end else if (gain_q == 5'd0) begin
                        // Reached here via a brief unmute at zero gain
                        state_d = StMuted;
                        presc_d = '0;
                    end else if (wrap) begin
                        gain_d = gain_q - 5'd1;
                        if (gain_q == 5'd1) begin
                            state_d = StMuted;
                            presc_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Mix, gain and FSM registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mix_l_q <= '0;
            mix_r_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            state_q <= StMuted;
            gain_q  <= '0;
            presc_q <= '0;
        end else begin
            mix_l_q <= mix_l_d;
            mix_r_q <= mix_r_d;
            left_q  <= left_d;
            right_q <= right_d;
            state_q <= state_d;
            gain_q  <= gain_d;
            presc_q <= presc_d;
        end
    end

    sigma_delta u_sd_left (
        .clock    (clock),
        .reset    (reset),
        .sample_i (left_q),
        .ds_o     (dsl)
    );

    sigma_delta u_sd_right (
        .clock    (clock),
        .reset    (reset),
        .sample_i (right_q),
        .ds_o     (dsr)
    );

    assign bus.left  = left_q;
    assign bus.right = right_q;
    assign bus.dsl   = dsl;
    assign bus.dsr   = dsr;

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: stimulus pushes expected left/right values
// tagged with the ce edge they are due on; a monitor pops and compares.
module tb_audio_mixer;
    import audio_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    audio_mixer_if bus ();

    audio_mixer #(.RAMP_SHIFT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          at;
        logic [14:0] l;
        logic [14:0] r;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   ce_cnt = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_at(input int at, input int l, input int r, input string name);
        exp_t e;
        e.at   = at;
        e.l    = 15'(l);
        e.r    = 15'(r);
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Return at the first falling edge after ce edge n has happened
    task automatic wait_ce(input int n);
        do @(negedge clock); while (ce_cnt < n);
    endtask

    task automatic drive(input logic [1:0] m, input int a, input int b, input int c,
                         input logic e, input logic mi);
        bus.mode = m;
        bus.a    = 12'(a);
        bus.b    = 12'(b);
        bus.c    = 12'(c);
        bus.ear  = e;
        bus.mic  = mi;
    endtask

    // Apply one input vector (ce running) and expect it two ce edges later
    task automatic vec(input string name, input logic [1:0] m, input int a, input int b,
                       input int c, input logic e, input logic mi, input int l, input int r);
        int k;
        k = ce_cnt;
        drive(m, a, b, c, e, mi);
        expect_at(k + 2, l, r, name);
        wait_ce(k + 3);
    endtask

    task automatic sample_ds(input int n, output int ones_l, output int ones_r,
                             output int toggles_l);
        logic prev;
        ones_l    = 0;
        ones_r    = 0;
        toggles_l = 0;
        prev      = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (i > 0 && bus.dsl != prev) toggles_l++;
            prev = bus.dsl;
            ones_l += int'(bus.dsl);
            ones_r += int'(bus.dsr);
        end
    endtask

    // Monitor: count ce edges since reset release, compare due entries
    always @(posedge clock) begin
        if (!reset) begin
            ce_cnt = 0;
        end else if (bus.ce) begin
            ce_cnt = ce_cnt + 1;
            #1;
            while (sb_q.size() > 0 && sb_q[0].at <= ce_cnt) begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, ".left"},  int'(bus.left),  int'(mon_e.l));
                check({mon_e.name, ".right"}, int'(bus.right), int'(mon_e.r));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: ce_cnt=%0d, required bench to finish in time", ce_cnt);
        $fatal(1, "bench timeout");
    end

    initial begin
        int m, s, k;
        int ol, orr, tl;

        bus.ce   = 1'b1;
        bus.mute = 1'b0;
        drive(MODE_ABC, 4095, 4095, 4095, 1'b0, 1'b0);
        #1 reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rst.left",  int'(bus.left),  0);
        check("rst.right", int'(bus.right), 0);
        check("rst.dsl",   int'(bus.dsl),   0);
        check("rst.dsr",   int'(bus.dsr),   0);

        // Ramp up from reset: wrap i lands on ce edge 1 + 256*i
        expect_at(257,  0,     0,     "ramp_g0");
        expect_at(258,  767,   767,   "ramp_g1");
        expect_at(4097, 11517, 11517, "ramp_g15");
        expect_at(4098, 12285, 12285, "ramp_full");
        reset = 1'b1;
        wait_ce(4100);

        vec("abc_a_only", MODE_ABC, 4095, 0, 0, 1'b0, 1'b0, 8190, 0);
        vec("acb",        MODE_ACB, 10, 100, 200, 1'b0, 1'b0, 220, 400);
        vec("mono3_max",  2'd3, 4095, 4095, 4095, 1'b1, 1'b1, 17404, 17404);
        vec("mono_16000", MODE_MONO, 4095, 4095, 2691, 1'b1, 1'b1, 16000, 16000);

        // Ramp down from full gain; step j lands on edge m + 256*j
        m = ce_cnt + 1;
        bus.mute = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            expect_at(m + 256 * j,     1000 * (17 - j), 1000 * (17 - j), "down_pre");
            expect_at(m + 256 * j + 1, 1000 * (16 - j), 1000 * (16 - j), "down_post");
        end
        wait_ce(m + 3338);

        // Unmute at gain 3: the ramp resumes upward from 3
        bus.mute = 1'b0;
        expect_at(m + 3340, 3000, 3000, "rev_hold3");
        expect_at(m + 3584, 3000, 3000, "rev_pre4");
        expect_at(m + 3585, 4000, 4000, "rev_up4");
        wait_ce(m + 3599);

        // Mute again and ramp all the way to silence
        bus.mute = 1'b1;
        expect_at(m + 3841, 3000, 3000, "fin_g3");
        expect_at(m + 4097, 2000, 2000, "fin_g2");
        expect_at(m + 4353, 1000, 1000, "fin_g1");
        expect_at(m + 4608, 1000, 1000, "fin_pre0");
        expect_at(m + 4609, 0,    0,    "fin_g0");
        expect_at(m + 5000, 0,    0,    "muted_hold");
        wait_ce(m + 5001);

        // Full-gain 16384 for the half-density sigma-delta pattern
        s = ce_cnt;
        bus.mute = 1'b0;
        drive(MODE_MONO, 4095, 4095, 3075, 1'b1, 1'b1);
        expect_at(s + 4098, 16384, 16384, "sd_level");
        wait_ce(s + 4100);
        bus.ce = 1'b0;
        drive(MODE_ABC, 1, 2, 3, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        check("hold.left",  int'(bus.left),  16384);
        check("hold.right", int'(bus.right), 16384);
        sample_ds(16, ol, orr, tl);
        check("sd_half.ones_l",    ol,  8);
        check("sd_half.ones_r",    orr, 8);
        check("sd_half.toggles_l", tl,  15);

        // Zero sample: no pulses
        bus.ce = 1'b1;
        vec("sd_zero", MODE_MONO, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        bus.ce = 1'b0;
        repeat (3) @(negedge clock);
        sample_ds(16, ol, orr, tl);
        check("sd_zero.ones_l", ol,  0);
        check("sd_zero.ones_r", orr, 0);

        // Quarter scale: exactly one pulse in every four clocks
        bus.ce = 1'b1;
        vec("sd_quarter", MODE_MONO, 4095, 4095, 2, 1'b0, 1'b0, 8192, 8192);
        bus.ce = 1'b0;
        repeat (3) @(negedge clock);
        for (int w = 0; w < 8; w++) begin
            sample_ds(4, ol, orr, tl);
            check("sd_quarter.win_l", ol,  1);
            check("sd_quarter.win_r", orr, 1);
        end

        // Reset in the middle of a ramp-down, then ramp up from zero again
        k = ce_cnt;
        bus.ce   = 1'b1;
        bus.mute = 1'b1;
        expect_at(k + 258, 7680, 7680, "pre_reset_g15");
        wait_ce(k + 260);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("midrst.left",  int'(bus.left),  0);
        check("midrst.right", int'(bus.right), 0);
        check("midrst.dsl",   int'(bus.dsl),   0);
        check("midrst.dsr",   int'(bus.dsr),   0);
        bus.mute = 1'b0;
        repeat (2) @(negedge clock);
        expect_at(257, 0,   0,   "rerun_g0");
        expect_at(258, 512, 512, "rerun_g1");
        reset = 1'b1;
        wait_ce(259);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_mixer.md
# audio_mixer

Downstream stage of the AY/YM PSG. Takes the three 12-bit channel levels plus the ULA beeper (ear/mic) bits and builds a left/right stereo pair in ABC, ACB or mono arrangement. Applies a click-free soft-mute gain ramp. Drives one first-order sigma-delta 1-bit DAC pin per side, as well as the parallel 15-bit samples.

## Interface
- RAMP_SHIFT, default 8: number of ce pulses per gain step, expressed as 2^RAMP_SHIFT.
- clock  in  1: system clock. Everything runs on its rising edge.
- reset  in  1: asynchronous, active-low reset.
- ce  in  1: sample-rate clock enable. This is the same enable that strobes the PSG outputs.
- a, b, c  in  12 each: PSG channel levels. Unsigned, 0..4095.
- ear  in  1: beeper ear bit.
- mic  in  1: beeper mic bit.
- mode  in  2: stereo arrangement. 0 = mono, 1 = ABC, 2 = ACB, 3 = mono.
- mute  in  1: level input. 1 requests a ramp down to silence, 0 requests a ramp up to full level.
- left, right  out  15 each: mixed samples after gain. Unsigned.
- dsl, dsr  out  1 each: sigma-delta bitstreams for the left and right outputs.

## Operation
- Stage 1 mix, registered on ce. All sums are formed at 15 bits with no truncation.
  - ABC: L = 2a + b, R = 2c + b.
  - ACB: L = 2a + c, R = 2b + c.
  - Mono (mode 0 or 3): L = R = a + b + c.
  - Both sides then add 4095 when ear = 1 and add 1024 when mic = 1.
  - Maximum value is 12285 + 4095 + 1024 = 17404, so the result never overflows 15 bits.
- Stage 2 gain, registered on ce.
  - left = (L × gain) >> 4 and right = (R × gain) >> 4.
  - gain is 5 bits, 0..16. gain = 16 passes the sample through exactly.
- Gain state machine: states MUTED, RAMP_UP, ACTIVE, RAMP_DOWN.
  - Reset state is MUTED with gain = 0.
  - MUTED: when mute = 0, go to RAMP_UP.
  - RAMP_UP: gain increments by 1 on each prescaler wrap. At gain 16, go to ACTIVE. If mute = 1, go to RAMP_DOWN from the current gain.
  - ACTIVE: when mute = 1, go to RAMP_DOWN.
  - RAMP_DOWN: gain decrements by 1 on each wrap. At gain 0, go to MUTED. If mute = 0, go to RAMP_UP from the current gain.
  - A direction reversal never changes gain by more than 1 per step.
- Prescaler: a RAMP_SHIFT-bit counter of ce pulses.
  - Free-running in the ramp states, wrapping every 2^RAMP_SHIFT ce.
  - Cleared on entry to MUTED or ACTIVE.
  - A full-scale ramp takes 16 × 2^RAMP_SHIFT ce pulses (4096 at the default).
- Sigma-delta, one instance per side, running every clock regardless of ce.
  - Update: {carry, acc[14:0]} <= acc[14:0] + sample, with carry registered as the ds output.
  - The density of ds is sample / 32768.
- mode, ear and mic are sampled only on ce. A change takes effect at the next ce, with no glitch between samples.

## Timing
- Reset values: left = right = 0, dsl = dsr = 0, accumulators = 0, gain = 0, prescaler = 0, state = MUTED.
- Input-to-sample latency: inputs present at ce edge n appear on left/right after ce edge n+1, i.e. two ce pulses.
- Gain used: stage 2 uses the gain held before the same edge.
- A gain step occurs on the ce where the prescaler wraps. Its effect appears on left/right at the following ce.
- ds latency: ds reflects left/right starting on the clock after they change, with one clock of latency.
- With ce = 0, left/right and the state machine hold. The sigma-delta keeps modulating the held sample.
- Reset asserted mid-ramp or mid-sample: all registers return to their reset values immediately. After release the block ramps up from 0 again if mute = 0.

## Structure
- Package audio_pkg holds:
  - mode constants MODE_MONO, MODE_ABC, MODE_ACB;
  - EAR_LEVEL = 4095 and MIC_LEVEL = 1024;
  - GAIN_MAX = 16;
  - the state encoding for the four states.
- Sub-module sigma_delta: 15-bit sample input, 1-bit output, clock/reset only. It is instantiated twice, once for dsl and once for dsr.

## Test plan
- Reset, then mute = 0 with a = b = c = 4095 in ABC mode. Required response:
  - left = right = 0 during reset;
  - gain reaches 16 after 4096 ce;
  - left = right = 12285 two ce later.
- ABC, gain 16, a = 4095, b = c = 0 -> left = 8190, right = 0 after two ce.
- ACB, gain 16, a = 10, b = 100, c = 200 -> left = 220, right = 400.
- Mono (mode 3), a = b = c = 4095, ear = mic = 1 -> left = right = 17404. No overflow.
- Assert mute when gain = 8, with L = 16000. Required response:
  - left steps 8000, then 7000, and so on, changing every 256 ce;
  - ends at 0 and the state reaches MUTED;
  - deasserting mute at gain 3 resumes the ramp upward from 3.
- Sigma-delta:
  - left held at 16384 -> dsl alternates 0/1 every clock;
  - left = 0 -> dsl stays 0;
  - left = 8192 -> exactly one 1 per four clocks.
